pid_seq_controller: RTL and testbench
=====================================

PID_SEQ_CONTROLLER -- requirements
Module: pid_seq_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning signed error/state width.
REQ-002 SHALL have parameter GAIN_W, default 16, meaning unsigned gain width, Q(GAIN_W-FRAC_BITS).FRAC_BITS.
REQ-003 SHALL have parameter FRAC_BITS, default 8, meaning gain fractional bits.
REQ-004 SHALL have parameter NUM_CH, default 4, meaning independent loops; CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have parameters I_MAX (default 4096), OUT_MIN (default 0) and OUT_MAX (default 1000), meaning the integrator clamp and the output saturation limits.
REQ-006 SHALL have ports clk (in, 1, clock) and rst_n (in, 1), with one clock and reset asynchronous active-low.
REQ-007 SHALL have ports err_valid (in, 1, sample offered) and err_ready (out, 1, sample accepted when both high).
REQ-008 SHALL have ports err_ch (in, CH_W, channel) and err_data (in, signed DATA_W, error sample).
REQ-009 SHALL have ports kp, ki and kd (in, GAIN_W each), meaning gains captured on acceptance.
REQ-010 SHALL have ports clr_valid (in, 1) and clr_ch (in, CH_W), meaning a request to clear one channel's state.
REQ-011 SHALL have ports out_valid (in→out, 1) and out_ready (in, 1), forming the result handshake; out_valid is an output.
REQ-012 SHALL have ports out_ch (out, CH_W), out_data (out, signed DATA_W) and out_sat (out, 1, meaning the result was clamped).

Function
REQ-013 SHALL hold per-channel integ[ch] (signed DATA_W), e_prev[ch] (signed DATA_W) and first[ch] (1 bit).
REQ-014 SHALL implement FSM IDLE→MUL_P→MUL_I→MUL_D→SUM→OUT→IDLE, advancing one state per clk except in OUT.
REQ-015 SHALL drive err_ready=1 only in IDLE; on acceptance it SHALL latch ch, e, kp, ki and kd, then enter MUL_P.
REQ-016 SHALL use one shared signed multiplier of DATA_W+1 by GAIN_W+1 bits, issuing one product per MUL state.
REQ-017 SHALL compute in MUL_P: p = kp*e.
REQ-018 SHALL compute in MUL_I: i_new = clamp(integ[ch]+e, -I_MAX, +I_MAX), using sum width DATA_W+1 with no wrap, then i_term = ki*i_new.
REQ-019 SHALL compute in MUL_D: d = first[ch] ? 0 : e - e_prev[ch], using width DATA_W+1, then d_term = kd*d.
REQ-020 SHALL in SUM form s = p + i_term + d_term at DATA_W+GAIN_W+3 bits, arithmetic-shift it right by FRAC_BITS, and saturate to [OUT_MIN, OUT_MAX].
REQ-021 SHALL set out_sat=1 iff that saturation changed the value.
REQ-022 SHALL in SUM commit integ[ch]=i_new, e_prev[ch]=e and first[ch]=0.
REQ-023 SHALL in OUT hold out_valid=1 and keep out_ch, out_data and out_sat stable until out_ready=1, then return to IDLE on the same edge.
REQ-024 SHALL give a latency of 5 clk from the acceptance edge to out_valid=1; back-to-back throughput SHALL be 1 sample per 6 clk when out_ready is held at 1.
REQ-025 SHALL honour clr_valid only in IDLE, setting integ[clr_ch]=0, e_prev[clr_ch]=0 and first[clr_ch]=1; when clr_valid is high outside IDLE it SHALL be ignored, and the requester holds it.
REQ-026 SHALL, when clr_valid and err_valid are both high in IDLE for the same channel, apply the clear first so that the sample sees the cleared state (D=0, integ=0).
REQ-027 SHALL ignore err_ch ≥ NUM_CH: such a sample is accepted and dropped, with no state change and no output, and the FSM stays in IDLE.
REQ-028 SHALL hold out_valid=0 in every state other than OUT.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force FSM=IDLE, out_valid=0, out_ch=0, out_data=0, out_sat=0, all integ=0, all e_prev=0 and all first=1.
REQ-030 SHALL make err_ready=1 on the first clk after rst_n deasserts.
REQ-031 SHALL, on reset during any non-IDLE state, discard the in-flight sample and leave no channel state partially committed.

Structure
REQ-032 SHALL place the FSM state enum typedef and the derived width localparams in package pid_seq_pkg.
REQ-033 SHALL implement the clamp/saturate function as sub-module pid_sat (combinational, parametrised by width and limits), used for both the integrator clamp and the output saturation.

Verification
REQ-034 SHALL verify, for kp=256, ki=0, kd=0, ch0, e=100, that out_data=100, out_sat=0 and out_valid rises 5 clk after acceptance.
REQ-035 SHALL verify, for kp=256 and e=5000, that out_data=1000 and out_sat=1; and for e=-50, that out_data=0 and out_sat=1.
REQ-036 SHALL verify, for ki=256, kp=0 and I_MAX=1000, that e=600 followed by e=600 on ch1 produces out_data 600 then 1000, with integ[1]=1000.
REQ-037 SHALL verify, for kd=256 on ch2, that e=10 gives d=0 (out 0) and a following e=30 gives out 20; after clr on ch2, e=50 SHALL give out 0.
REQ-038 SHALL verify that with out_ready held at 0 for 4 clk, out_data stays stable and err_ready=0, and that after release the next sample is accepted within 1 clk.
REQ-039 SHALL verify that rst_n pulsed low during MUL_I gives out_valid=0, integ[ch] unchanged at 0, and that the next sample on that channel sees first=1.

Source files
------------

// File: rtl/pid_seq_controller_pkg.sv
// Shared types and width helpers for the sequential multi-channel PID controller.
package pid_seq_pkg;

    // One state per pipeline step; OUT waits on the result handshake.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_I = 3'd2,
        MUL_D = 3'd3,
        SUM   = 3'd4,
        OUT   = 3'd5
    } state_t;

    // Channel index width: at least one bit even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Multiplier operands: error plus sign headroom, gain plus a zero sign bit.
    function automatic int mul_a_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int mul_b_width(input int gain_w);
        return gain_w + 1;
    endfunction

    // Accumulator for the three products.
    function automatic int sum_width(input int data_w, input int gain_w);
        return data_w + gain_w + 3;
    endfunction

    localparam int DATA_W_DEF = 32;
    localparam int GAIN_W_DEF = 16;
    localparam int NUM_CH_DEF = 4;
    localparam int CH_W_DEF   = ch_width(NUM_CH_DEF);
    localparam int A_W_DEF    = mul_a_width(DATA_W_DEF);
    localparam int B_W_DEF    = mul_b_width(GAIN_W_DEF);
    localparam int S_W_DEF    = sum_width(DATA_W_DEF, GAIN_W_DEF);

endpackage

// File: rtl/pid_seq_controller_if.sv
// Sample / clear / result handshake bundle for pid_seq_controller.
interface pid_seq_controller_if #(
    parameter int DATA_W = 32,
    parameter int GAIN_W = 16,
    parameter int NUM_CH = 4
);
    import pid_seq_pkg::*;

    localparam int CH_W = ch_width(NUM_CH);

    logic                     err_valid;
    logic                     err_ready;
    logic [CH_W-1:0]          err_ch;
    logic signed [DATA_W-1:0] err_data;
    logic [GAIN_W-1:0]        kp;
    logic [GAIN_W-1:0]        ki;
    logic [GAIN_W-1:0]        kd;
    logic                     clr_valid;
    logic [CH_W-1:0]          clr_ch;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output err_valid, err_ch, err_data, kp, ki, kd, clr_valid, clr_ch, out_ready,
        input  err_ready, out_valid, out_ch, out_data, out_sat
    );

    modport slave (
        input  err_valid, err_ch, err_data, kp, ki, kd, clr_valid, clr_ch, out_ready,
        output err_ready, out_valid, out_ch, out_data, out_sat
    );

endinterface

// File: rtl/pid_seq_controller_sat.sv
// Combinational signed clamp of a wide value into [MIN_V, MAX_V], narrowed to OUT_W.
module pid_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32,
    parameter int MIN_V = 0,
    parameter int MAX_V = 1000
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val
);
    localparam logic signed [IN_W-1:0] LO = IN_W'(MIN_V);
    localparam logic signed [IN_W-1:0] HI = IN_W'(MAX_V);

    // Pick the limit when out of range, otherwise pass the value through.
    always_comb begin
        if (i_val < LO) begin
            o_val = OUT_W'(LO);
        end else if (i_val > HI) begin
            o_val = OUT_W'(HI);
        end else begin
            o_val = OUT_W'(i_val);
        end
    end

endmodule

// File: rtl/pid_seq_controller.sv
// Time-multiplexed PID controller: one shared multiplier, per-channel integrator state.
module pid_seq_controller
    import pid_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int GAIN_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int NUM_CH    = 4,
    parameter int I_MAX     = 4096,
    parameter int OUT_MIN   = 0,
    parameter int OUT_MAX   = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pid_seq_controller_if.slave  bus
);
    localparam int CH_W = ch_width(NUM_CH);
    localparam int A_W  = mul_a_width(DATA_W);
    localparam int B_W  = mul_b_width(GAIN_W);
    localparam int P_W  = A_W + B_W;
    localparam int S_W  = sum_width(DATA_W, GAIN_W);

    state_t                   r_state, w_next;
    logic                     w_err_ready, w_out_valid, w_accept, w_ch_ok, w_clr_ok;
    logic [CH_W-1:0]          r_ch;
    logic signed [DATA_W-1:0] r_e;
    logic [GAIN_W-1:0]        r_kp, r_ki, r_kd;
    logic signed [P_W-1:0]    r_p, r_i, r_d;
    logic signed [DATA_W-1:0] r_i_new;
    logic signed [DATA_W-1:0] r_integ [NUM_CH];
    logic signed [DATA_W-1:0] r_eprev [NUM_CH];
    logic [NUM_CH-1:0]        r_first;
    logic [CH_W-1:0]          r_out_ch;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_sat;
    logic signed [A_W-1:0]    w_mul_a, w_isum, w_d;
    logic signed [B_W-1:0]    w_mul_b;
    logic signed [P_W-1:0]    w_prod;
    logic signed [DATA_W-1:0] w_i_new, w_out_val;
    logic signed [S_W-1:0]    w_sum, w_shift;
    logic                     w_out_sat;

    assign w_ch_ok  = int'(bus.err_ch) < NUM_CH;
    assign w_clr_ok = int'(bus.clr_ch) < NUM_CH;
    assign w_accept = bus.err_valid && w_err_ready;

    // Integrator update and derivative are only consumed once r_ch holds a valid channel.
    assign w_isum = A_W'(r_integ[r_ch]) + A_W'(r_e);
    assign w_d    = r_first[r_ch] ? '0 : A_W'(r_e) - A_W'(r_eprev[r_ch]);
    assign w_prod = P_W'(w_mul_a) * P_W'(w_mul_b);

    assign w_sum   = S_W'(r_p) + S_W'(r_i) + S_W'(r_d);
    assign w_shift = w_sum >>> FRAC_BITS;
    assign w_out_sat = (w_shift != S_W'(w_out_val));

    pid_sat #(.IN_W(A_W), .OUT_W(DATA_W), .MIN_V(-I_MAX), .MAX_V(I_MAX)) u_integ_clamp (
        .i_val (w_isum),
        .o_val (w_i_new)
    );

    pid_sat #(.IN_W(S_W), .OUT_W(DATA_W), .MIN_V(OUT_MIN), .MAX_V(OUT_MAX)) u_out_sat (
        .i_val (w_shift),
        .o_val (w_out_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: out-of-range channels are swallowed without leaving IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept && w_ch_ok) w_next = MUL_P;
            MUL_P:   w_next = MUL_I;
            MUL_I:   w_next = MUL_D;
            MUL_D:   w_next = SUM;
            SUM:     w_next = OUT;
            OUT:     if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs and shared multiplier operand selection.
    always_comb begin
        w_err_ready = (r_state == IDLE);
        w_out_valid = (r_state == OUT);
        w_mul_a     = '0;
        w_mul_b     = '0;
        unique case (r_state)
            MUL_P: begin
                w_mul_a = A_W'(r_e);
                w_mul_b = {1'b0, r_kp};
            end
            MUL_I: begin
                w_mul_a = A_W'(w_i_new);
                w_mul_b = {1'b0, r_ki};
            end
            MUL_D: begin
                w_mul_a = w_d;
                w_mul_b = {1'b0, r_kd};
            end
            default: ;
        endcase
    end

    // Sample capture, product pipeline and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch       <= '0;
            r_e        <= '0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_p        <= '0;
            r_i        <= '0;
            r_d        <= '0;
            r_i_new    <= '0;
            r_out_ch   <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_accept && w_ch_ok) begin
                    r_ch <= bus.err_ch;
                    r_e  <= bus.err_data;
                    r_kp <= bus.kp;
                    r_ki <= bus.ki;
                    r_kd <= bus.kd;
                end
                MUL_P: r_p <= w_prod;
                MUL_I: begin
                    r_i     <= w_prod;
                    r_i_new <= w_i_new;
                end
                MUL_D: r_d <= w_prod;
                SUM: begin
                    r_out_ch   <= r_ch;
                    r_out_data <= w_out_val;
                    r_out_sat  <= w_out_sat;
                end
                default: ;
            endcase
        end
    end

    // Per-channel state: clears land in IDLE (ahead of a same-cycle sample), commits in SUM only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_integ[i] <= '0;
                r_eprev[i] <= '0;
            end
            r_first <= '1;
        end else if (r_state == IDLE) begin
            if (bus.clr_valid && w_clr_ok) begin
                r_integ[bus.clr_ch] <= '0;
                r_eprev[bus.clr_ch] <= '0;
                r_first[bus.clr_ch] <= 1'b1;
            end
        end else if (r_state == SUM) begin
            r_integ[r_ch] <= r_i_new;
            r_eprev[r_ch] <= r_e;
            r_first[r_ch] <= 1'b0;
        end
    end

    assign bus.err_ready = w_err_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_pid_seq_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences, randomized traffic.
module tb_pid_seq_controller;
    import pid_seq_pkg::*;

    localparam int NCH   = 3;
    localparam int IMAX  = 1000;
    localparam int OMIN  = 0;
    localparam int OMAX  = 1000;
    localparam int FRAC  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    pid_seq_controller_if #(.DATA_W(32), .GAIN_W(16), .NUM_CH(NCH)) bus ();

    pid_seq_controller #(
        .DATA_W(32), .GAIN_W(16), .FRAC_BITS(FRAC), .NUM_CH(NCH),
        .I_MAX(IMAX), .OUT_MIN(OMIN), .OUT_MAX(OMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: per-channel PID state kept as plain integers.
    longint m_integ [NCH];
    longint m_eprev [NCH];
    bit     m_first [NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_integ[i] = 0;
            m_eprev[i] = 0;
            m_first[i] = 1'b1;
        end
    endfunction

    function automatic void model_step(input int ch, input longint e, input longint kp,
                                       input longint ki, input longint kd,
                                       output longint od, output bit os);
        longint inew, d, s, sh;
        inew = m_integ[ch] + e;
        if (inew > IMAX) inew = IMAX;
        if (inew < -IMAX) inew = -IMAX;
        d  = m_first[ch] ? 0 : e - m_eprev[ch];
        s  = kp * e + ki * inew + kd * d;
        sh = s >>> FRAC;
        od = (sh < OMIN) ? OMIN : (sh > OMAX) ? OMAX : sh;
        os = (od != sh);
        m_integ[ch] = inew;
        m_eprev[ch] = e;
        m_first[ch] = 1'b0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the acceptance edge.
    task automatic send(input int ch, input int e, input int kp, input int ki, input int kd,
                        input bit clr, input int cch, output int acc);
        int t = 0;
        while (!bus.err_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.err_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL err_ready_wait: got 0 expected 1 within 20 cycles");
        end
        bus.err_valid = 1'b1;
        bus.err_ch    = 2'(ch);
        bus.err_data  = 32'(e);
        bus.kp        = 16'(kp);
        bus.ki        = 16'(ki);
        bus.kd        = 16'(kd);
        bus.clr_valid = clr;
        bus.clr_ch    = 2'(cch);
        acc = cyc;
        @(negedge clk);
        bus.err_valid = 1'b0;
        bus.clr_valid = 1'b0;
    endtask

    // Waits for the result, compares it, optionally stalls, then completes the handshake.
    task automatic get_result(input int ech, input longint edata, input bit esat,
                              input int acc, input bit chk_lat, input int stall);
        int t = 0;
        longint held;
        if (stall > 0) bus.out_ready = 1'b0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL out_valid_wait: got 0 expected 1 within 20 cycles");
            bus.out_ready = 1'b1;
            return;
        end
        if (chk_lat) check("latency", longint'(cyc - acc), 5);
        check("out_ch", longint'(bus.out_ch), longint'(ech));
        check("out_data", longint'(bus.out_data), edata);
        check("out_sat", longint'(bus.out_sat), longint'(esat));
        held = longint'(bus.out_data);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_data", longint'(bus.out_data), held);
            check("stall_valid", longint'(bus.out_valid), 1);
            check("stall_err_ready", longint'(bus.err_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        if (stall > 0) check("ready_after_release", longint'(bus.err_ready), 1);
    endtask

    typedef struct {
        int ch;
        int e;
        int kp;
        int ki;
        int kd;
        bit clr;
        int exp_data;
        bit exp_sat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int     acc;
        longint od;
        bit     os;

        bus.err_valid = 1'b0;
        bus.err_ch    = '0;
        bus.err_data  = '0;
        bus.kp        = '0;
        bus.ki        = '0;
        bus.kd        = '0;
        bus.clr_valid = 1'b0;
        bus.clr_ch    = '0;
        bus.out_ready = 1'b1;

        tbl[0] = '{ch:0, e:100,  kp:256, ki:0,   kd:0,   clr:0, exp_data:100,  exp_sat:0};
        tbl[1] = '{ch:0, e:5000, kp:256, ki:0,   kd:0,   clr:0, exp_data:1000, exp_sat:1};
        tbl[2] = '{ch:0, e:-50,  kp:256, ki:0,   kd:0,   clr:0, exp_data:0,    exp_sat:1};
        tbl[3] = '{ch:1, e:600,  kp:0,   ki:256, kd:0,   clr:0, exp_data:600,  exp_sat:0};
        tbl[4] = '{ch:1, e:600,  kp:0,   ki:256, kd:0,   clr:0, exp_data:1000, exp_sat:0};
        tbl[5] = '{ch:2, e:10,   kp:0,   ki:0,   kd:256, clr:0, exp_data:0,    exp_sat:0};
        tbl[6] = '{ch:2, e:30,   kp:0,   ki:0,   kd:256, clr:0, exp_data:20,   exp_sat:0};
        tbl[7] = '{ch:2, e:50,   kp:0,   ki:0,   kd:256, clr:1, exp_data:0,    exp_sat:0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_sat", longint'(bus.out_sat), 0);
        check("rst_out_ch", longint'(bus.out_ch), 0);
        check("rst_integ0", longint'(dut.r_integ[0]), 0);
        check("rst_first2", longint'(dut.r_first[2]), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_err_ready", longint'(bus.err_ready), 1);
        model_reset();

        // Reset while the sample sits in MUL_I: nothing may be committed.
        send(0, 77, 0, 256, 256, 1'b0, 0, acc);
        @(negedge clk);
        check("midrst_state", longint'(dut.r_state), longint'(MUL_I));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_integ0", longint'(dut.r_integ[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        send(0, 40, 0, 0, 256, 1'b0, 0, acc);
        model_step(0, 40, 0, 0, 256, od, os);
        get_result(0, od, os, acc, 1'b0, 0);
        check("midrst_first_d0", longint'(bus.out_data), 0);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].clr) begin
                m_integ[tbl[i].ch] = 0;
                m_eprev[tbl[i].ch] = 0;
                m_first[tbl[i].ch] = 1'b1;
            end
            send(tbl[i].ch, tbl[i].e, tbl[i].kp, tbl[i].ki, tbl[i].kd, tbl[i].clr, tbl[i].ch, acc);
            model_step(tbl[i].ch, tbl[i].e, tbl[i].kp, tbl[i].ki, tbl[i].kd, od, os);
            get_result(tbl[i].ch, tbl[i].exp_data, tbl[i].exp_sat, acc, (i == 0), 0);
        end
        check("integ1_clamped", longint'(dut.r_integ[1]), 1000);

        // Result held under back-pressure for 4 cycles, then released.
        send(0, 200, 256, 0, 0, 1'b0, 0, acc);
        model_step(0, 200, 256, 0, 0, od, os);
        get_result(0, od, os, acc, 1'b1, 4);

        // Out-of-range channel is accepted and dropped.
        send(3, 123, 256, 0, 0, 1'b0, 0, acc);
        check("drop_err_ready", longint'(bus.err_ready), 1);
        check("drop_out_valid", longint'(bus.out_valid), 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int ch, e, kp, ki, kd, cch, stall;
            bit clr;
            ch    = int'($urandom_range(3, 0));
            e     = int'($urandom_range(6000, 0)) - 3000;
            kp    = int'($urandom_range(600, 0));
            ki    = int'($urandom_range(600, 0));
            kd    = int'($urandom_range(600, 0));
            clr   = ($urandom_range(4, 0) == 0);
            cch   = int'($urandom_range(3, 0));
            stall = int'($urandom_range(2, 0));
            if (clr && cch < NCH) begin
                m_integ[cch] = 0;
                m_eprev[cch] = 0;
                m_first[cch] = 1'b1;
            end
            send(ch, e, kp, ki, kd, clr, cch, acc);
            if (ch >= NCH) begin
                check("rnd_drop_idle", longint'(bus.err_ready), 1);
                check("rnd_drop_no_out", longint'(bus.out_valid), 0);
            end else begin
                model_step(ch, e, kp, ki, kd, od, os);
                get_result(ch, od, os, acc, 1'b1, stall);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
